sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, SDRAM row/column address width.
REQ-002 SHALL have parameter BA_W, default 2, bank-select width.
REQ-003 SHALL have parameter DQ_W, default 16, data width.
REQ-004 SHALL have parameter OP_TIMEOUT, default 1024, max cycles per granted operation; counter width is $clog2(OP_TIMEOUT+1).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 init_cmd  in  4  init client {CSn,RASn,CASn,WEn}.
REQ-008 init_addr  in  ADDR_W  init client address.
REQ-009 init_done  in  1  init sequence complete (level).
REQ-010 aref_req  in  1  refresh client request (level).
REQ-011 aref_cmd  in  4  refresh client command.
REQ-012 aref_addr  in  ADDR_W  refresh client address.
REQ-013 aref_en  out  1  one-cycle refresh grant pulse.
REQ-014 aref_done  in  1  refresh complete pulse.
REQ-015 wr_req / rd_req  in  1 each  write / read requests (level).
REQ-016 wr_cmd / rd_cmd  in  4 each  write / read client commands.
REQ-017 wr_addr / rd_addr  in  BA_W+ADDR_W each  {bank, address}.
REQ-018 wr_dq  in  DQ_W  write data.
REQ-019 wr_en / rd_en  out  1 each  one-cycle grant pulses.
REQ-020 wr_done / rd_done  in  1 each  completion pulses.
REQ-021 sdram_cmd  out  4  {CSn,RASn,CASn,WEn} to PHY.
REQ-022 sdram_addr  out  ADDR_W; sdram_ba  out  BA_W  to PHY.
REQ-023 sdram_dq_out  out  DQ_W; sdram_dq_oe  out  1  write data and output enable.
REQ-024 err_timeout  out  1  one-cycle pulse on operation timeout.

Function
REQ-025 States (one-hot, 5 bits): INIT, ARBIT, AREF, WRITE, READ.
REQ-026 INIT->ARBIT on the clock edge where init_done=1; all other inputs ignored in INIT.
REQ-027 In ARBIT, priority: refresh (aref_req or ref_pend) > write > read; at that edge state moves to the target and the matching *_en is registered high for exactly one cycle.
REQ-028 ARBIT with no request: stays in ARBIT; no grant.
REQ-029 AREF/WRITE/READ->ARBIT on the matching *_done; at least one ARBIT cycle separates operations.
REQ-030 ref_pend set when aref_req=1 outside ARBIT/INIT; cleared when aref_en issues.
REQ-031 Timeout counter clears on entering an operation state and increments each cycle there; at OP_TIMEOUT without done, return to ARBIT and pulse err_timeout.
REQ-032 done and timeout in the same cycle: done wins; no err_timeout.
REQ-033 *_done for a non-active client is ignored.
REQ-034 Combinational output mux: INIT -> init_cmd/init_addr, ba=0; AREF -> aref_cmd/aref_addr, ba=0; WRITE/READ -> client cmd, addr=[ADDR_W-1:0], ba=upper BA_W bits; ARBIT -> cmd 4'b0111 (NOP), addr=0, ba=0.
REQ-035 sdram_dq_oe=1 only in WRITE; sdram_dq_out=wr_dq in WRITE, else 0.

Reset
REQ-036 rst_n=0 at an edge: state=INIT, all *_en=0, err_timeout=0, ref_pend=0, counter=0, round-robin flag=0; applies mid-operation, and the next edge after release starts in INIT.

Configuration
REQ-037 SDRAM_RR_ARB_EN defined: when wr_req and rd_req are both high in ARBIT (no refresh pending), grant the client not granted last (flag tracks last write/read grant; after reset write wins first).
REQ-038 SDRAM_RR_ARB_EN undefined: write always beats read; no round-robin flag.

Verification
REQ-039 Reset, init_done high at cycle 10 -> INIT outputs pass through until then, ARBIT at cycle 11, sdram_cmd=4'b0111.
REQ-040 aref_req and wr_req high together in ARBIT -> aref_en pulses 1 cycle, state AREF; after aref_done, ARBIT, then wr_en.
REQ-041 aref_req pulses during WRITE -> ref_pend set; after wr_done, aref_en is the next grant.
REQ-042 OP_TIMEOUT=8, grant read, rd_done never asserted -> err_timeout pulse after 8 cycles in READ, back to ARBIT.
REQ-043 wr_req and rd_req held high, 4 grants -> without macro: W,W,W,W; with SDRAM_RR_ARB_EN: W,R,W,R.
REQ-044 rst_n low for 1 cycle during WRITE -> state INIT, sdram_dq_oe=0, wr_en=0 on the next cycle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM PHY to one of four clients (init, refresh,
// write, read) and muxes the granted client's command/address/data onto the PHY.
// Optional build macro SDRAM_RR_ARB_EN: alternate write/read grants when both
// request together; when undefined, write always beats read.
module sdram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int BA_W       = 2,
  parameter int DQ_W       = 16,
  parameter int OP_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             init_cmd,
  input  logic [ADDR_W-1:0]      init_addr,
  input  logic                   init_done,
  input  logic                   aref_req,
  input  logic [3:0]             aref_cmd,
  input  logic [ADDR_W-1:0]      aref_addr,
  output logic                   aref_en,
  input  logic                   aref_done,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic [3:0]             wr_cmd,
  input  logic [3:0]             rd_cmd,
  input  logic [BA_W+ADDR_W-1:0] wr_addr,
  input  logic [BA_W+ADDR_W-1:0] rd_addr,
  input  logic [DQ_W-1:0]        wr_dq,
  output logic                   wr_en,
  output logic                   rd_en,
  input  logic                   wr_done,
  input  logic                   rd_done,
  output logic [3:0]             sdram_cmd,
  output logic [ADDR_W-1:0]      sdram_addr,
  output logic [BA_W-1:0]        sdram_ba,
  output logic [DQ_W-1:0]        sdram_dq_out,
  output logic                   sdram_dq_oe,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(OP_TIMEOUT + 1);
  // Last counter value seen in an operation state before the timeout edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_TIMEOUT - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [4:0] {
    INIT  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  state_t           state_q;
  logic             aref_en_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic             err_timeout_q;
  logic             ref_pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pick_wr_d;
  logic             op_done_d;
`ifdef SDRAM_RR_ARB_EN
  logic             rr_last_wr_q;
`endif

  // Write-vs-read choice when no refresh is wanted, and done of the active client
  always_comb begin
    pick_wr_d = wr_req;
`ifdef SDRAM_RR_ARB_EN
    if (wr_req && rd_req) begin
      pick_wr_d = !rr_last_wr_q;
    end
`endif
    op_done_d = 1'b0;
    case (state_q)
      AREF:    op_done_d = aref_done;
      WRITE:   op_done_d = wr_done;
      READ:    op_done_d = rd_done;
      default: op_done_d = 1'b0;
    endcase
  end

  // Arbitration FSM with registered grant pulses, timeout counter and refresh pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      ref_pend_q    <= 1'b0;
      cnt_q         <= '0;
`ifdef SDRAM_RR_ARB_EN
      rr_last_wr_q  <= 1'b0;
`endif
    end else begin
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (init_done) state_q <= ARBIT;
        end
        ARBIT: begin
          cnt_q <= '0;
          if (aref_req || ref_pend_q) begin
            state_q    <= AREF;
            aref_en_q  <= 1'b1;
            ref_pend_q <= 1'b0;
          end else if (pick_wr_d) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
`ifdef SDRAM_RR_ARB_EN
            rr_last_wr_q <= 1'b1;
`endif
          end else if (rd_req) begin
            state_q <= READ;
            rd_en_q <= 1'b1;
`ifdef SDRAM_RR_ARB_EN
            rr_last_wr_q <= 1'b0;
`endif
          end
        end
        AREF, WRITE, READ: begin
          // A refresh request arriving mid-operation must not be lost
          if (aref_req) ref_pend_q <= 1'b1;
          if (op_done_d) begin
            state_q <= ARBIT;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= ARBIT;
            err_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign err_timeout = err_timeout_q;

  // PHY output mux driven by the current owner of the bus
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_ba     = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (state_q)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd    = wr_cmd;
        sdram_addr   = wr_addr[ADDR_W-1:0];
        sdram_ba     = wr_addr[BA_W+ADDR_W-1:ADDR_W];
        sdram_dq_out = wr_dq;
        sdram_dq_oe  = 1'b1;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr[ADDR_W-1:0];
        sdram_ba   = rd_addr[BA_W+ADDR_W-1:ADDR_W];
      end
      default: begin
        sdram_cmd = CMD_NOP;
      end
    endcase
  end

endmodule
